// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder
//   Receives PS/2 keyboard frames and turns the extended arrow-key scan codes
//   into a direction code plus held-key levels.
//
//   Frame path : two-flop synchronizers -> falling-edge detect -> frame FSM
//                (start, 8 data bits LSB first, odd parity, stop) -> byte strobe.
//   Decode path: prefix FSM (E0 extended, F0 break) -> dir / held flags.
//
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   PS2_CLK    in   raw keyboard clock (asynchronous)
//   PS2_DAT    in   raw keyboard data (asynchronous)
//   dir        out  last arrow made: 0 left, 1 right, 2 up, 3 down
//   dir_valid  out  one-cycle pulse when dir is updated by an arrow make
//   left/right/up/down out  held-key levels
//   frame_err  out  one-cycle pulse on parity, stop-bit or timeout error
module ps2_arrow_decoder #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} dec_state_t;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == CODE_LEFT) || (code == CODE_RIGHT) ||
           (code == CODE_UP)   || (code == CODE_DOWN);
  endfunction

  // Index into the held vector, which is ordered to match the dir encoding.
  function automatic logic [1:0] arrow_dir(input logic [7:0] code);
    logic [1:0] d;
    d = 2'd0;
    case (code)
      CODE_LEFT:  d = 2'd0;
      CODE_RIGHT: d = 2'd1;
      CODE_UP:    d = 2'd2;
      CODE_DOWN:  d = 2'd3;
      default:    d = 2'd0;
    endcase
    return d;
  endfunction

  // ---- stage p0/p1: synchronizers, p2: previous synchronized clock ----
  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_dat_p0, ps2_dat_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Idle-high line levels so no edge is seen on the way out of reset.
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= PS2_CLK;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      ps2_dat_p0 <= PS2_DAT;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  logic fall;
  logic bit_in;
  assign fall   = ps2_clk_p2 & ~ps2_clk_p1;
  assign bit_in = ps2_dat_p1;

  // ---- stage p3: frame FSM and byte strobe ----
  frame_state_t    fstate;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic [TW-1:0]   tmo_cnt;
  logic            byte_vld_p3;
  logic [7:0]      byte_p3;

  logic timeout_hit;
  logic stop_ok;
  logic err_set;

  always_comb begin
    timeout_hit = (fstate != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));
    // Odd parity: data ones plus parity bit must be odd; stop bit must be 1.
    stop_ok     = bit_in && (^{shift, parity_bit});
    err_set     = timeout_hit || ((fstate == STOP) && fall && !stop_ok);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fstate      <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      parity_bit  <= 1'b0;
      tmo_cnt     <= '0;
      byte_vld_p3 <= 1'b0;
      byte_p3     <= 8'd0;
      frame_err   <= 1'b0;
    end else begin
      byte_vld_p3 <= 1'b0;
      frame_err   <= err_set;

      if ((fstate == IDLE) || fall) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + TW'(1);

      if (timeout_hit) begin
        fstate  <= IDLE;
        bit_cnt <= 3'd0;
      end else if (fall) begin
        case (fstate)
          IDLE: begin
            if (!bit_in) begin
              fstate  <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) fstate <= PARITY;
          end
          PARITY: begin
            parity_bit <= bit_in;
            fstate     <= STOP;
          end
          STOP: begin
            fstate <= IDLE;
            if (stop_ok) begin
              byte_vld_p3 <= 1'b1;
              byte_p3     <= shift;
            end
          end
          default: fstate <= IDLE;
        endcase
      end
    end
  end

  // ---- stage p4: prefix decoder and registered outputs ----
  dec_state_t dstate;
  logic [3:0] held;

  assign left  = held[0];
  assign right = held[1];
  assign up    = held[2];
  assign down  = held[3];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dstate    <= BASE;
      dir       <= 2'd1;
      dir_valid <= 1'b0;
      held      <= 4'd0;
    end else begin
      dir_valid <= 1'b0;
      // err_set is registered into frame_err on this same edge, so the
      // decoder is already in BASE during the cycle frame_err is high.
      if (err_set) begin
        dstate <= BASE;
      end else if (byte_vld_p3) begin
        case (dstate)
          BASE: begin
            if (byte_p3 == CODE_EXT)      dstate <= EXT;
            else if (byte_p3 == CODE_BRK) dstate <= BRK;
            else                          dstate <= BASE;
          end
          EXT: begin
            if (byte_p3 == CODE_BRK) begin
              dstate <= EXT_BRK;
            end else if (byte_p3 == CODE_EXT) begin
              dstate <= EXT;
            end else begin
              dstate <= BASE;
              if (is_arrow(byte_p3)) begin
                dir                  <= arrow_dir(byte_p3);
                dir_valid            <= 1'b1;
                held[arrow_dir(byte_p3)] <= 1'b1;
              end
            end
          end
          BRK: begin
            // Break of a non-extended key: swallow the code.
            dstate <= BASE;
          end
          EXT_BRK: begin
            dstate <= BASE;
            if (is_arrow(byte_p3)) held[arrow_dir(byte_p3)] <= 1'b0;
          end
          default: dstate <= BASE;
        endcase
      end
    end
  end

endmodule
